// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants and the run-sequencer state type.
package cnn_pkg;

    localparam int ADDR_W    = 12;
    localparam int L1_DEPTH  = 2562;
    localparam int L2_THRESH = 2500;
    localparam int L2_TOTAL  = 1024;
    localparam int CNT2_W    = 11;
    localparam int WDOG_CYC  = 65535;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_L1_RUN   = 3'd1,
        ST_OVERLAP  = 3'd2,
        ST_L2_DRAIN = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } seq_state_t;

endpackage

// File: rtl/cnn_seq_wdog.sv
// Sequencer watchdog: counts idle cycles while enabled, flags when WDOG_CYC is reached.
module cnn_seq_wdog #(
    parameter int WDOG_CYC = 65535
) (
    input  logic clk,
    input  logic global_rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    import cnn_pkg::*;

    localparam int CW = $clog2(WDOG_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (global_rst || clear)
            cnt <= '0;
        else if (en && cnt != CW'(WDOG_CYC))
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == CW'(WDOG_CYC));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Run-level controller for the two-layer CNN: layer starts, intermediate buffer addressing, read stall.
// Optional watchdog built when CNN_SEQ_WDOG_EN is defined.
module cnn_layer_sequencer #(
    parameter int ADDR_W    = cnn_pkg::ADDR_W,
    parameter int L1_DEPTH  = cnn_pkg::L1_DEPTH,
    parameter int L2_THRESH = cnn_pkg::L2_THRESH,
    parameter int L2_TOTAL  = cnn_pkg::L2_TOTAL,
    parameter int CNT2_W    = cnn_pkg::CNT2_W,
    parameter int WDOG_CYC  = cnn_pkg::WDOG_CYC
) (
    input  logic              clk,
    input  logic              global_rst,
    input  logic              cal_start,
    output logic              l1_start,
    input  logic              l1_valid,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic              l2_start,
    input  logic              l2_rd_req,
    input  logic [ADDR_W-1:0] l2_rd_addr,
    output logic              l2_rd_stall,
    input  logic              l2_valid,
    output logic [CNT2_W-1:0] outcount2,
    output logic              end_cnn,
    output logic              busy,
    output logic              err
);
    import cnn_pkg::*;

    if (L1_DEPTH >= 2**ADDR_W) begin : g_bad_depth
        $error("L1_DEPTH must fit in ADDR_W bits without wrapping");
    end
    if (L2_TOTAL >= 2**CNT2_W) begin : g_bad_total
        $error("L2_TOTAL must fit in CNT2_W bits");
    end
    if (WDOG_CYC < 1) begin : g_bad_wdog
        $error("WDOG_CYC must be positive");
    end

    seq_state_t        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_acc;
    logic              cnt_full;
    logic              l2_active;
    logic              wdog_trip;

    assign wr_acc      = l1_valid && (state == ST_L1_RUN || state == ST_OVERLAP);
    assign buf_wr_en   = wr_acc;
    assign buf_wr_addr = wr_ptr;
    // No write-through in the buffer: a same-cycle write to the read address still stalls.
    assign l2_rd_stall = l2_rd_req && (l2_rd_addr >= wr_ptr) && (state != ST_L2_DRAIN);
    assign cnt_full    = (outcount2 == CNT2_W'(L2_TOTAL));
    assign l2_active   = (state == ST_OVERLAP) || (state == ST_L2_DRAIN);
    assign busy        = (state == ST_L1_RUN) || l2_active || (state == ST_DONE);

`ifdef CNN_SEQ_WDOG_EN
    seq_state_t prev_state;

    always_ff @(posedge clk) begin
        if (global_rst) prev_state <= ST_IDLE;
        else            prev_state <= state;
    end

    cnn_seq_wdog #(.WDOG_CYC(WDOG_CYC)) u_wdog (
        .clk        (clk),
        .global_rst (global_rst),
        .clear      (l1_valid || l2_valid || (state != prev_state)),
        .en         ((state == ST_L1_RUN) || l2_active),
        .expired    (wdog_trip)
    );
`else
    assign wdog_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (global_rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            outcount2 <= '0;
            l1_start  <= 1'b0;
            l2_start  <= 1'b0;
            end_cnn   <= 1'b0;
            err       <= 1'b0;
        end else begin
            l1_start <= 1'b0;
            l2_start <= 1'b0;
            end_cnn  <= 1'b0;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (l2_valid && l2_active && !cnt_full)
                outcount2 <= outcount2 + 1'b1;

            if (wdog_trip) begin
                err   <= 1'b1;
                state <= ST_ERR;
            end else begin
                case (state)
                    ST_IDLE: if (cal_start) begin
                        wr_ptr    <= '0;
                        outcount2 <= '0;
                        err       <= 1'b0;
                        l1_start  <= 1'b1;
                        state     <= ST_L1_RUN;
                    end
                    ST_L1_RUN: if (wr_ptr == ADDR_W'(L2_THRESH)) begin
                        l2_start <= 1'b1;
                        state    <= ST_OVERLAP;
                    end
                    // Layer 2 finishing before layer 1 has drained means the run is corrupt.
                    ST_OVERLAP: if (cnt_full) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end else if (wr_acc && wr_ptr == ADDR_W'(L1_DEPTH - 1)) begin
                        state <= ST_L2_DRAIN;
                    end
                    ST_L2_DRAIN: if (l1_valid) begin
                        err   <= 1'b1;
                        state <= ST_ERR;
                    end else if (cnt_full) begin
                        end_cnn <= 1'b1;
                        state   <= ST_DONE;
                    end
                    ST_DONE: state <= ST_IDLE;
                    // The recovering cal_start is consumed here; a new run needs another request.
                    ST_ERR: if (cal_start) begin
                        err   <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Bench for cnn_layer_sequencer: directed scenarios with random read traffic against a count-based model.
module tb_cnn_layer_sequencer;

    localparam int DEPTH  = 8;
    localparam int THRESH = 5;
    localparam int TOTAL  = 4;

    logic        clk = 1'b0;
    logic        global_rst = 1'b0;
    logic        cal_start = 1'b0, l1_valid = 1'b0, l2_valid = 1'b0, l2_rd_req = 1'b0;
    logic [11:0] l2_rd_addr = '0;
    logic        l1_start, buf_wr_en, l2_start, l2_rd_stall, end_cnn, busy, err;
    logic [11:0] buf_wr_addr;
    logic [10:0] outcount2;

    cnn_layer_sequencer #(
        .ADDR_W(12), .L1_DEPTH(DEPTH), .L2_THRESH(THRESH), .L2_TOTAL(TOTAL),
        .CNT2_W(11), .WDOG_CYC(20)
    ) dut (
        .clk(clk), .global_rst(global_rst), .cal_start(cal_start), .l1_start(l1_start),
        .l1_valid(l1_valid), .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr),
        .l2_start(l2_start), .l2_rd_req(l2_rd_req), .l2_rd_addr(l2_rd_addr),
        .l2_rd_stall(l2_rd_stall), .l2_valid(l2_valid), .outcount2(outcount2),
        .end_cnn(end_cnn), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Model: run progress expressed as counts and milestone flags.
    bit m_busy, m_rel, m_l1done, m_end, m_errst, m_err, m_l1s, m_l2s;
    int m_wr, m_cnt;
    bit mdl_on = 1'b1;

    // Observations
    int  n_l1s, n_end, obs_wr, l2s_at;
    bit  last_stall, last_busy;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_busy = 0; m_rel = 0; m_l1done = 0; m_end = 0; m_errst = 0; m_err = 0;
        m_l1s = 0; m_l2s = 0; m_wr = 0; m_cnt = 0;
    endtask

    task automatic model_fault();
        m_busy = 0; m_err = 1; m_errst = 1;
    endtask

    task automatic step(input bit c, input bit v1, input bit v2, input bit rq, input logic [11:0] ad);
        bit e_wen, e_stall, counting, n1, n2, ne;
        @(negedge clk);
        cal_start = c; l1_valid = v1; l2_valid = v2; l2_rd_req = rq; l2_rd_addr = ad;
        #1;
        if (l1_start === 1'b1) n_l1s++;
        if (end_cnn === 1'b1) n_end++;
        if (l2_start === 1'b1) l2s_at = obs_wr;
        if (buf_wr_en === 1'b1) obs_wr++;
        last_stall = l2_rd_stall;
        last_busy  = busy;
        if (mdl_on) begin
            e_wen   = v1 && m_busy && !m_end && !m_l1done;
            e_stall = rq && (int'(ad) >= m_wr) && !(m_busy && m_l1done && !m_end);
            chk("l1_start", int'(l1_start), int'(m_l1s));
            chk("l2_start", int'(l2_start), int'(m_l2s));
            chk("end_cnn", int'(end_cnn), int'(m_end));
            chk("busy", int'(busy), int'(m_busy));
            chk("err", int'(err), int'(m_err));
            chk("outcount2", int'(outcount2), m_cnt);
            chk("buf_wr_addr", int'(buf_wr_addr), m_wr);
            chk("buf_wr_en", int'(buf_wr_en), int'(e_wen));
            chk("l2_rd_stall", int'(l2_rd_stall), int'(e_stall));
            n1 = 0; n2 = 0; ne = 0;
            counting = m_busy && m_rel && !m_end;
            if (!m_busy) begin
                if (c && m_errst) begin
                    m_errst = 0; m_err = 0;
                end else if (c) begin
                    m_busy = 1; m_rel = 0; m_l1done = 0; m_err = 0;
                    m_wr = 0; m_cnt = 0; n1 = 1;
                end
            end else if (m_end) begin
                m_busy = 0;
            end else begin
                if (m_rel && !m_l1done && m_cnt == TOTAL) model_fault();
                else if (!m_rel) begin
                    if (m_wr == THRESH) begin m_rel = 1; n2 = 1; end
                end else if (!m_l1done) begin
                    if (v1 && m_wr == DEPTH - 1) m_l1done = 1;
                end else if (v1) model_fault();
                else if (m_cnt == TOTAL) ne = 1;
            end
            if (counting && v2 && m_cnt < TOTAL) m_cnt++;
            if (e_wen) m_wr++;
            m_l1s = n1; m_l2s = n2; m_end = ne;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rstep(input bit c, input bit v1, input bit v2);
        step(c, v1, v2, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 9)));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        global_rst = 1; cal_start = 0; l1_valid = 0; l2_valid = 0; l2_rd_req = 0; l2_rd_addr = '0;
        @(posedge clk);
        #1;
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_l1s"}, int'(l1_start), 0);
        chk({tag, "_l2s"}, int'(l2_start), 0);
        chk({tag, "_end"}, int'(end_cnn), 0);
        chk({tag, "_cnt"}, int'(outcount2), 0);
        chk({tag, "_addr"}, int'(buf_wr_addr), 0);
        chk({tag, "_wen"}, int'(buf_wr_en), 0);
        model_clear();
        @(negedge clk);
        global_rst = 0;
    endtask

    task automatic finish_run(input string tag);
        int k = 0;
        while (last_busy && k < 60) begin
            rstep(0, 0, 1'($urandom_range(0, 1)));
            k++;
        end
        chk({tag, "_ends"}, int'(k < 60), 1);
    endtask

    task automatic obs_clear();
        n_l1s = 0; n_end = 0; obs_wr = 0; l2s_at = -1;
    endtask

    initial begin
        int k;
        model_clear();
        obs_clear();
        do_reset("rst0");

        // Nominal back-to-back run
        obs_clear();
        rstep(1, 0, 0);
        chk("nom_l1s_latency", int'(l1_start), 1);
        for (int i = 0; i < DEPTH; i++) rstep(0, 1, 0);
        for (int i = 0; i < TOTAL; i++) rstep(0, 0, 1);
        finish_run("nom");
        chk("nom_l2s_at", l2s_at, 6);
        chk("nom_end_once", n_end, 1);
        chk("nom_cnt", int'(outcount2), 4);
        chk("nom_err", int'(err), 0);
        chk("nom_writes", obs_wr, DEPTH);

        // Randomly interleaved runs, both valids allowed in one cycle
        for (int r = 0; r < 3; r++) begin
            obs_clear();
            rstep(1, 0, 0);
            k = 0;
            while (m_wr < DEPTH && k < 100) begin
                rstep(0, ($urandom_range(0, 3) != 0), (m_rel && m_cnt < TOTAL - 1 && $urandom_range(0, 1) == 1));
                k++;
            end
            finish_run("rnd");
            chk("rnd_end_once", n_end, 1);
            chk("rnd_err", int'(err), 0);
        end

        // Read stall around the write pointer
        rstep(1, 0, 0);
        for (int i = 0; i < 6; i++) rstep(0, 1, 0);
        step(0, 0, 0, 1, 12'd6);
        chk("stall_ahead", int'(last_stall), 1);
        step(0, 0, 0, 1, 12'd5);
        chk("stall_behind", int'(last_stall), 0);
        step(0, 1, 0, 1, 12'd6);
        chk("stall_same_cycle_wr", int'(last_stall), 1);
        rstep(0, 1, 0);
        finish_run("stall");

        // Overrun in drain, then recovery
        obs_clear();
        rstep(1, 0, 0);
        for (int i = 0; i < DEPTH; i++) rstep(0, 1, 0);
        rstep(0, 1, 0);
        chk("ovr_no_wen", obs_wr, DEPTH);
        rstep(0, 0, 0);
        chk("ovr_err", int'(err), 1);
        chk("ovr_idle", int'(busy), 0);
        rstep(1, 0, 0);
        rstep(0, 0, 0);
        chk("ovr_err_clr", int'(err), 0);

        // Reset mid-run, then a clean run
        rstep(1, 0, 0);
        for (int i = 0; i < 3; i++) rstep(0, 1, 0);
        do_reset("rst_mid");
        obs_clear();
        rstep(1, 0, 0);
        for (int i = 0; i < DEPTH; i++) rstep(0, 1, 0);
        finish_run("post_rst");
        chk("post_rst_end", n_end, 1);

        // Layer 2 finishing early, with a cal_start while busy
        rstep(1, 0, 0);
        for (int i = 0; i < 6; i++) rstep(0, 1, 0);
        obs_clear();
        rstep(1, 0, 1);
        for (int i = 0; i < TOTAL - 1; i++) rstep(0, 0, 1);
        for (int i = 0; i < 3; i++) rstep(0, 0, 0);
        chk("early_err", int'(err), 1);
        chk("early_no_end", n_end, 0);
        chk("busy_cal_ignored", n_l1s, 0);
        rstep(1, 0, 0);

        // Layer 1 stalls at wr_ptr=3
        rstep(1, 0, 0);
        for (int i = 0; i < 3; i++) rstep(0, 1, 0);
        obs_clear();
`ifdef CNN_SEQ_WDOG_EN
        mdl_on = 0;
        k = 0;
        while (err !== 1'b1 && k < 40) begin
            step(0, 0, 0, 0, 12'd0);
            k++;
        end
        chk("wdog_trip_window", int'(k >= 19 && k <= 23), 1);
        chk("wdog_err", int'(err), 1);
        chk("wdog_no_end", n_end, 0);
        mdl_on = 1;
        do_reset("rst_wdog");
`else
        for (int i = 0; i < 100; i++) rstep(0, 0, 0);
        chk("hang_busy", int'(busy), 1);
        chk("hang_err", int'(err), 0);
        chk("hang_no_end", n_end, 0);
        do_reset("rst_hang");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
